// File: rtl/bitbang_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bitbang_seq                                                      |
// | Brief   : Step-FIFO driven bit-bang sequencer with synchronised pin capture |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bitbang_seq #(
  parameter int IO_NUM_OF  = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_wr_valid,
  input  logic [IO_NUM_OF-1:0] in_wr_dir,
  input  logic [IO_NUM_OF-1:0] in_wr_outval,
  output logic                 out_wr_ready,
  input  logic [DIV_WIDTH-1:0] in_divider,
  input  logic                 in_start,
  input  logic                 in_abort,
  output logic                 out_rd_valid,
  output logic [IO_NUM_OF-1:0] out_rd_data,
  input  logic                 in_rd_ready,
  output logic                 out_busy,
  output logic                 out_overflow,
  inout  wire  [IO_NUM_OF-1:0] io_pins
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_pw = c_aw + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_HOLD   = 2'd2,
    S_SAMPLE = 2'd3
  } state_t;

  state_t                   r_state;
  logic [DIV_WIDTH-1:0]     r_cnt;
  logic [IO_NUM_OF-1:0]     r_dir;
  logic [IO_NUM_OF-1:0]     r_out;
  logic [IO_NUM_OF-1:0]     r_sync1;
  logic [IO_NUM_OF-1:0]     r_sync2;
  logic                     r_overflow;

  logic [2*IO_NUM_OF-1:0]   r_step_mem [FIFO_DEPTH];
  logic [c_pw-1:0]          r_step_wp;
  logic [c_pw-1:0]          r_step_rp;
  logic [IO_NUM_OF-1:0]     r_cap_mem [FIFO_DEPTH];
  logic [c_pw-1:0]          r_cap_wp;
  logic [c_pw-1:0]          r_cap_rp;

  logic w_step_empty;
  logic w_step_full;
  logic w_step_push;
  logic w_cap_empty;
  logic w_cap_full;
  logic w_cap_pop;
  logic w_cap_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_step_empty = (r_step_wp == r_step_rp);
  assign w_step_full  = (r_step_wp[c_aw] != r_step_rp[c_aw]) &&
                        (r_step_wp[c_aw-1:0] == r_step_rp[c_aw-1:0]);
  assign w_cap_empty  = (r_cap_wp == r_cap_rp);
  assign w_cap_full   = (r_cap_wp[c_aw] != r_cap_rp[c_aw]) &&
                        (r_cap_wp[c_aw-1:0] == r_cap_rp[c_aw-1:0]);

  assign w_step_push = in_wr_valid && !w_step_full && !in_abort;
  assign w_cap_pop   = !w_cap_empty && in_rd_ready;
  assign w_cap_push  = (r_state == S_SAMPLE) && !in_abort && (!w_cap_full || w_cap_pop);

  assign out_wr_ready = !w_step_full;
  assign out_rd_valid = !w_cap_empty;
  assign out_rd_data  = r_cap_mem[r_cap_rp[c_aw-1:0]];
  assign out_busy     = (r_state != S_IDLE);
  assign out_overflow = r_overflow;

  generate
    for (genvar i = 0; i < IO_NUM_OF; i++) begin : g_pad
      assign io_pins[i] = r_dir[i] ? r_out[i] : 1'bz;
    end
  endgenerate

  always_ff @(posedge in_clk) begin
    if (w_step_push) r_step_mem[r_step_wp[c_aw-1:0]] <= {in_wr_dir, in_wr_outval};
    if (w_cap_push)  r_cap_mem[r_cap_wp[c_aw-1:0]]   <= r_sync2;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dir      <= '0;
      r_out      <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_overflow <= 1'b0;
      r_step_wp  <= '0;
      r_step_rp  <= '0;
      r_cap_wp   <= '0;
      r_cap_rp   <= '0;
    end else begin
      r_sync1 <= io_pins;
      r_sync2 <= r_sync1;
      if (w_step_push) r_step_wp <= r_step_wp + c_pw'(1);
      if (w_cap_push)  r_cap_wp  <= r_cap_wp + c_pw'(1);
      if (w_cap_pop)   r_cap_rp  <= r_cap_rp + c_pw'(1);

      if (in_abort) begin
        // Flush by catching the read pointer up; capture contents survive.
        r_state   <= S_IDLE;
        r_step_rp <= r_step_wp;
        r_dir     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_start && !w_step_empty) begin
              r_state    <= S_APPLY;
              r_overflow <= 1'b0;
            end
          end
          S_APPLY: begin
            {r_dir, r_out} <= r_step_mem[r_step_rp[c_aw-1:0]];
            r_step_rp      <= r_step_rp + c_pw'(1);
            r_cnt          <= in_divider;
            r_state        <= S_HOLD;
          end
          S_HOLD: begin
            if (r_cnt == '0) r_state <= S_SAMPLE;
            else             r_cnt   <= r_cnt - DIV_WIDTH'(1);
          end
          S_SAMPLE: begin
            if (w_cap_full && !w_cap_pop) r_overflow <= 1'b1;
            r_state <= w_step_empty ? S_IDLE : S_APPLY;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitbang_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bitbang_seq                                                   |
// | Brief   : Directed bench with a step-timeline reference model              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bitbang_seq;

  localparam int IO  = 10;
  localparam int DEP = 8;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [IO-1:0] wr_dir = '0;
  logic [IO-1:0] wr_out = '0;
  logic          wr_ready;
  logic [DW-1:0] divider = 16'd4;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rd_valid;
  logic [IO-1:0] rd_data;
  logic          rd_ready = 1'b0;
  logic          busy;
  logic          overflow;
  wire  [IO-1:0] pins;

  logic [IO-1:0] ext_val = '0;
  logic [IO-1:0] ext_en  = '1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // External driver fills exactly the pins the sequencer is expected to leave floating.
  for (genvar i = 0; i < IO; i++) begin : g_ext
    assign pins[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  bitbang_seq #(.IO_NUM_OF(IO), .FIFO_DEPTH(DEP), .DIV_WIDTH(DW)) dut (
    .in_clk       (clk),
    .in_rst_n     (rst_n),
    .in_wr_valid  (wr_valid),
    .in_wr_dir    (wr_dir),
    .in_wr_outval (wr_out),
    .out_wr_ready (wr_ready),
    .in_divider   (divider),
    .in_start     (start),
    .in_abort     (abort),
    .out_rd_valid (rd_valid),
    .out_rd_data  (rd_data),
    .in_rd_ready  (rd_ready),
    .out_busy     (busy),
    .out_overflow (overflow),
    .io_pins      (pins)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a step is a period of divider+3 cycles counted by position.
  logic [2*IO-1:0] m_q[$];
  logic [IO-1:0]   m_cap[$];
  logic [IO-1:0]   m_dir = '0;
  logic [IO-1:0]   m_out = '0;
  logic [IO-1:0]   m_s1 = '0;
  logic [IO-1:0]   m_s2 = '0;
  bit              m_busy = 0;
  bit              m_ovf = 0;
  bit              m_valid = 0;
  int              m_pos = 0;
  int              m_div = 0;

  always @(posedge clk) begin : model
    logic [IO-1:0]   pins_now;
    logic [IO-1:0]   old_s2;
    logic [2*IO-1:0] w;
    int              qn;
    int              cn;
    bit              pop;
    bit              acc_wr;
    pins_now = (m_dir & m_out) | (~m_dir & ext_val);
    if (!rst_n) begin
      m_q.delete();
      m_cap.delete();
      m_dir = '0; m_out = '0; m_s1 = '0; m_s2 = '0;
      m_busy = 0; m_ovf = 0; m_pos = 0; m_valid = 1;
    end else begin
      qn = m_q.size();
      cn = m_cap.size();
      pop = rd_ready && (cn > 0);
      old_s2 = m_s2;
      m_s2 = m_s1;
      m_s1 = pins_now;
      if (pop) void'(m_cap.pop_front());
      if (abort) begin
        m_q.delete();
        m_dir = '0;
        m_busy = 0;
      end else begin
        acc_wr = wr_valid && (qn < DEP);
        if (!m_busy) begin
          if (start && qn > 0) begin m_busy = 1; m_pos = 0; m_ovf = 0; end
        end else if (m_pos == 0) begin
          w = m_q.pop_front();
          m_dir = w[2*IO-1:IO];
          m_out = w[IO-1:0];
          m_div = int'(divider);
          m_pos = 1;
        end else if (m_pos <= m_div + 1) begin
          m_pos++;
        end else begin
          if (cn < DEP || pop) m_cap.push_back(old_s2);
          else m_ovf = 1;
          if (qn > 0) m_pos = 0;
          else m_busy = 0;
        end
        if (acc_wr) m_q.push_back({wr_dir, wr_out});
      end
    end
    ext_en <= ~m_dir;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEP));
      chk("rd_valid", 32'(rd_valid), 32'(m_cap.size() > 0));
      if (m_cap.size() > 0) chk("rd_data", 32'(rd_data), 32'(m_cap[0]));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("pins", 32'(pins), 32'((m_dir & m_out) | (~m_dir & ext_val)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IO-1:0] d, input logic [IO-1:0] o);
    wr_dir = d; wr_out = o; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic read_one(input logic [IO-1:0] exp);
    chk("read_valid", 32'(rd_valid), 32'd1);
    chk("read_data", 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c1, c2, c3;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Two-step playback, divider 4: each step visible for 7 cycles.
    divider = 16'd4;
    push(10'h3FF, 10'h155);
    push(10'h3FF, 10'h2AA);
    start_pulse();
    c1 = -1; c2 = -1; c3 = -1;
    for (int k = 1; k < 40; k++) begin
      tick();
      if (pins == 10'h155 && c1 < 0) c1 = k;
      if (pins == 10'h2AA && c2 < 0) c2 = k;
      if (!busy && c3 < 0) c3 = k;
    end
    chk("apply_latency", 32'(c1), 32'd1);
    chk("step1_len", 32'(c2 - c1), 32'd7);
    chk("step2_to_idle", 32'(c3 - c2), 32'd6);
    chk("pins_hold_last", 32'(pins), 32'h2AA);
    read_one(10'h155);
    read_one(10'h2AA);

    // Nine pushes into an 8-deep FIFO; the ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      push(10'h3FF, IO'(i));
      if (i == 7) chk("full_after_8", 32'(wr_ready), 32'd0);
    end
    divider = 16'd1;
    start_pulse();
    wait_idle(200);
    chk("no_ovf_at_8", 32'(overflow), 32'd0);

    // Capture FIFO now full: the next sample is dropped.
    push(10'h3FF, 10'h3C0);
    start_pulse();
    wait_idle(50);
    chk("ovf_set", 32'(overflow), 32'd1);
    push(10'h3FF, 10'h3C1);
    start_pulse();
    chk("ovf_clear_on_start", 32'(overflow), 32'd0);
    wait_idle(50);
    chk("ovf_set_again", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) read_one(IO'(i));
    chk("cap_drained", 32'(rd_valid), 32'd0);

    // Abort during HOLD of step 2 of 4, with a write in the same cycle.
    divider = 16'd4;
    ext_val = 10'h000;
    for (int i = 0; i < 4; i++) push(10'h3FF, 10'h3FF);
    start_pulse();
    for (int i = 0; i < 9; i++) tick();
    abort = 1'b1; wr_valid = 1'b1; wr_dir = 10'h3FF; wr_out = 10'h001;
    tick();
    abort = 1'b0; wr_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_ready", 32'(wr_ready), 32'd1);
    chk("abort_pins_z", 32'(pins), 32'h000);
    read_one(10'h3FF);
    chk("abort_one_sample", 32'(rd_valid), 32'd0);
    start_pulse();
    chk("start_empty_idle", 32'(busy), 32'd0);
    ext_val = 10'h155;
    tick();
    chk("abort_pins_float", 32'(pins), 32'h155);

    // Loopback: pins 4-7 driven high, the rest supplied externally.
    ext_val = 10'h30F;
    push(10'h0F0, 10'h0F0);
    start_pulse();
    wait_idle(50);
    chk("loop_pins", 32'(pins), 32'h3FF);
    read_one(10'h3FF);

    // Fill capture, set overflow mid-playback, then reset during HOLD.
    divider = 16'd1;
    for (int i = 0; i < 8; i++) push(10'h3FF, IO'(i + 16));
    start_pulse();
    wait_idle(200);
    divider = 16'd4;
    push(10'h3FF, 10'h0AA);
    push(10'h3FF, 10'h055);
    start_pulse();
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_pins", 32'(pins), 32'(ext_val));
    start_pulse();
    chk("rst_start_empty", 32'(busy), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bitbang_seq.md
BITBANG_SEQ -- requirements
Module: bitbang_seq

Interface
REQ-001 SHALL have parameter IO_NUM_OF, default 10: number of bidirectional pins.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8 (power of two, >=2): depth of the step FIFO and of the capture FIFO.
REQ-003 SHALL have parameter DIV_WIDTH, default 16: width of the step-period divider.
REQ-004 in_clk  input  1  sole clock; all state on rising edge.
REQ-005 in_rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_wr_valid  input  1  push one step word into the step FIFO.
REQ-007 in_wr_dir  input  IO_NUM_OF  step direction per pin, 1=drive, 0=tristate.
REQ-008 in_wr_outval  input  IO_NUM_OF  step output value per pin.
REQ-009 out_wr_ready  output  1  step FIFO not full.
REQ-010 in_divider  input  DIV_WIDTH  hold-cycle count per step.
REQ-011 in_start  input  1  begin playback of the step FIFO.
REQ-012 in_abort  input  1  stop playback, flush the step FIFO, tristate all pins.
REQ-013 out_rd_valid  output  1  capture FIFO not empty.
REQ-014 out_rd_data  output  IO_NUM_OF  capture FIFO head: sampled pin levels.
REQ-015 in_rd_ready  input  1  pop the capture FIFO when out_rd_valid=1.
REQ-016 out_busy  output  1  sequencer not in IDLE.
REQ-017 out_overflow  output  1  sticky: a sample was dropped because the capture FIFO was full.
REQ-018 io_pins  inout  IO_NUM_OF  pads; pin i = dir_reg[i] ? out_reg[i] : Z.

Function
REQ-019 Step FIFO SHALL accept a word when in_wr_valid=1 and out_wr_ready=1; writes while full SHALL be ignored; out_wr_ready=!full, with no same-cycle pass-through.
REQ-020 Every pin input SHALL pass through a 2-flop synchroniser before sampling.
REQ-021 FSM states SHALL be IDLE, APPLY, HOLD, SAMPLE.
REQ-022 IDLE -> APPLY SHALL occur when in_start=1 and the step FIFO is not empty; in_start with an empty FIFO SHALL leave the FSM in IDLE; in_start outside IDLE SHALL be ignored.
REQ-023 APPLY (1 cycle) SHALL pop the FIFO head into dir_reg/out_reg, load the hold counter with in_divider, then go to HOLD; new pin values SHALL appear the cycle after APPLY.
REQ-024 HOLD SHALL last in_divider+1 cycles (counter decrements to 0, inclusive), then go to SAMPLE.
REQ-025 SAMPLE (1 cycle) SHALL push the synchronised pin levels into the capture FIFO, then go to APPLY if the step FIFO is not empty, else IDLE.
REQ-026 Back-to-back step period SHALL be exactly in_divider+3 cycles.
REQ-027 In IDLE after playback, dir_reg/out_reg SHALL hold the last step's values.
REQ-028 SAMPLE with the capture FIFO full SHALL drop the sample and set out_overflow; a simultaneous in_rd_ready pop SHALL free the slot, so no drop occurs.
REQ-029 out_overflow SHALL clear only on reset or on an accepted start (IDLE->APPLY).
REQ-030 in_abort SHALL take priority over every other input: FSM -> IDLE, step FIFO emptied, dir_reg=0 on the next cycle; an in-progress sample SHALL NOT be pushed; capture FIFO contents SHALL be kept.
REQ-031 A step FIFO write in the same cycle as in_abort SHALL be discarded.
REQ-032 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full/empty SHALL be decoded from the MSB difference.
REQ-033 out_busy SHALL be 1 in APPLY, HOLD and SAMPLE, and 0 in IDLE.

Reset
REQ-034 With in_rst_n=0 at a clock edge: FSM=IDLE, both FIFOs empty, dir_reg=0, out_reg=0, counter=0, synchronisers=0, out_overflow=0.
REQ-035 After reset: out_wr_ready=1, out_rd_valid=0, out_busy=0, all io_pins=Z; reset mid-playback SHALL obey the same values.

Verification
REQ-036 IO_NUM_OF=10, divider=4; push steps dir=3FF out=155, then dir=3FF out=2AA; start -> pins=155 for 7 cycles, then 2AA for 7 cycles; capture reads 155 then 2AA; busy low afterwards; pins stay at 2AA.
REQ-037 Push FIFO_DEPTH+1 words with no start -> out_wr_ready=0 after the 8th word, 9th ignored; playback yields 8 samples.
REQ-038 Capture FIFO full, in_rd_ready=0, 9 steps -> out_overflow=1, 8 samples held; next start clears out_overflow.
REQ-039 Abort during HOLD of step 2 of 4 -> next cycle IDLE, pins=Z, out_wr_ready=1, exactly 1 sample in the capture FIFO.
REQ-040 dir=0F0, external drive 30F on undriven pins, loopback -> captured sample 3FF (pins 4-7 return 1 via out=0F0).
REQ-041 in_rst_n=0 during HOLD -> next cycle all outputs at reset values; start with empty FIFO -> busy stays 0.
